// File: rtl/odo_pkg.sv
// Shared constants, FSM state type and the pre-mix arithmetic for the odo pre-mix engine.
package odo_pkg;
  localparam int WORD_W  = 64;
  localparam int N_WORDS = 10;
  localparam int STATE_W = 640;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FOLD  = 2'd1,
    ST_APPLY = 2'd2,
    ST_DONE  = 2'd3
  } odo_state_e;

  function automatic logic [WORD_W-1:0] odo_fold(input logic [STATE_W-1:0] s);
    logic [WORD_W-1:0] t;
    t = '0;
    for (int w = 0; w < N_WORDS; w++) t ^= s[w*WORD_W +: WORD_W];
    return t;
  endfunction

  // Every word gets the same mask, so applying it twice restores the input.
  function automatic logic [STATE_W-1:0] odo_apply(input logic [STATE_W-1:0] s,
                                                   input logic [WORD_W-1:0]  total);
    logic [STATE_W-1:0] r;
    logic [WORD_W-1:0]  m;
    m = total ^ (total >> 32);
    for (int w = 0; w < N_WORDS; w++) r[w*WORD_W +: WORD_W] = s[w*WORD_W +: WORD_W] ^ m;
    return r;
  endfunction

  function automatic logic [STATE_W-1:0] odo_premix(input logic [STATE_W-1:0] s);
    return odo_apply(s, odo_fold(s));
  endfunction
endpackage

// File: rtl/odo_rr_arbiter.sv
// Round-robin grant; the priority pointer advances only when a grant is issued (accept).
module odo_rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int ID_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  gnt_id_o
);
  logic [ID_W-1:0] last_q;
  logic            found;
  int              idx;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_q) + k) % N_REQ;
      if (!found && req_i[idx]) begin
        found    = 1'b1;
        gnt_id_o = ID_W'(idx);
      end
    end
    if (en_i && found) gnt_o[gnt_id_o] = 1'b1;
  end

  // A grant is only raised toward a valid requester, so any grant is an accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       last_q <= ID_W'(N_REQ - 1);
    else if (|gnt_o) last_q <= gnt_id_o;
  end
endmodule

// File: rtl/odo_pre_mix_arb.sv
// Arbitrated pre-mix engine; define ODO_PREMIX_SERIAL_EN for the one-word-per-cycle fold build.
module odo_pre_mix_arb
  import odo_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int ID_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [STATE_W*N_REQ-1:0] req_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [STATE_W-1:0]       out_data,
  output logic [ID_W-1:0]          out_id,
  output logic                     busy
);
  odo_state_e         state_q, state_d;
  logic [STATE_W-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]    out_id_q, out_id_d;
  logic [ID_W-1:0]    gnt_id;
  logic [N_REQ-1:0]   gnt;
  logic               arb_en;
  logic               accept;
  logic [STATE_W-1:0] gnt_data;
`ifdef ODO_PREMIX_SERIAL_EN
  logic [STATE_W-1:0] data_q, data_d;
  logic [WORD_W-1:0]  acc_q, acc_d;
  logic [3:0]         idx_q, idx_d;
`endif

  // Held off during reset so no grant can be seen while rst is high.
  assign arb_en = (state_q == ST_IDLE) && !rst;

  odo_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req_valid),
    .en_i    (arb_en),
    .gnt_o   (gnt),
    .gnt_id_o(gnt_id)
  );

  assign req_ready = gnt;
  assign accept    = |(req_valid & gnt);
  assign gnt_data  = req_data[gnt_id*STATE_W +: STATE_W];

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
`ifdef ODO_PREMIX_SERIAL_EN
    data_d     = data_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
`endif
    case (state_q)
      ST_IDLE: if (accept) begin
        out_id_d = gnt_id;
`ifdef ODO_PREMIX_SERIAL_EN
        data_d   = gnt_data;
        acc_d    = '0;
        idx_d    = '0;
        state_d  = ST_FOLD;
`else
        out_data_d = odo_premix(gnt_data);
        state_d    = ST_DONE;
`endif
      end
`ifdef ODO_PREMIX_SERIAL_EN
      ST_FOLD: begin
        acc_d = acc_q ^ data_q[idx_q*WORD_W +: WORD_W];
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'(N_WORDS - 1)) begin
          idx_d   = '0;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        out_data_d = odo_apply(data_q, acc_q);
        state_d    = ST_DONE;
      end
`endif
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      out_data_q <= '0;
      out_id_q   <= '0;
`ifdef ODO_PREMIX_SERIAL_EN
      data_q     <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
`ifdef ODO_PREMIX_SERIAL_EN
      data_q     <= data_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
`endif
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_odo_pre_mix_arb.sv
// Bench for odo_pre_mix_arb: directed cases plus randomized traffic against a behavioural model.
module tb_odo_pre_mix_arb;
  localparam int N_REQ = 2;
  localparam int SW    = 640;
`ifdef ODO_PREMIX_SERIAL_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 1;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [SW*N_REQ-1:0]  req_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SW-1:0]        out_data;
  logic [0:0]           out_id;
  logic                 busy;

  int checks = 0;
  int errors = 0;
  int last_g = N_REQ - 1;

  always #5 clk = ~clk;

  odo_pre_mix_arb #(.N_REQ(N_REQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .busy(busy)
  );

  function automatic logic [SW-1:0] ref_premix(input logic [SW-1:0] s);
    logic [63:0]   w [10];
    logic [63:0]   total;
    logic [SW-1:0] r;
    total = 64'd0;
    for (int i = 0; i < 10; i++) begin
      w[i]  = s[i*64 +: 64];
      total = total ^ w[i];
    end
    for (int i = 0; i < 10; i++) r[i*64 +: 64] = w[i] ^ total ^ (total >> 32);
    return r;
  endfunction

  function automatic int rr_pick(input int last, input logic [N_REQ-1:0] vm);
    for (int k = 1; k <= N_REQ; k++)
      if (vm[(last + k) % N_REQ]) return (last + k) % N_REQ;
    return -1;
  endfunction

  function automatic logic [SW-1:0] rand_state();
    logic [SW-1:0] s;
    for (int i = 0; i < SW/32; i++) s[i*32 +: 32] = $urandom;
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_g = N_REQ - 1;
  endtask

  // Called at a negedge; returns at the negedge where out_valid is first seen.
  task automatic txn(input logic [N_REQ-1:0] vm, input bit keep, output logic [N_REQ-1:0] rdy,
                     output int lat, output logic [SW-1:0] od, output int oid, output bit to);
    int n;
    to = 1'b0; rdy = '0; lat = 0; od = '0; oid = -1;
    req_valid = vm; out_ready = 1'b0;
    #1;
    n = 0;
    while (req_ready == '0 && n < 20) begin @(negedge clk); n++; end
    if (req_ready == '0) begin to = 1'b1; req_valid = '0; return; end
    rdy = req_ready;
    @(posedge clk); #1;
    if (!keep) req_valid = '0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 30);
    if (!out_valid) begin to = 1'b1; return; end
    od = out_data; oid = int'(out_id);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b11; out_ready = 1'b0; req_data = {rand_state(), rand_state()};
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (out_id !== 1'b0) begin errors++; $display("FAIL reset_out_id got %0d want 0", out_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
    rst = 1'b0; req_valid = '0;
    last_g = N_REQ - 1;
    @(negedge clk);
  endtask

  task automatic test_req0_zero();
    logic [N_REQ-1:0] rdy; int lat; logic [SW-1:0] od; int oid; bit to;
    req_data = '0;
    txn(2'b01, 1'b0, rdy, lat, od, oid, to);
    checks++; if (to) begin errors++; $display("FAIL req0_zero_timeout got timeout want result"); end
    checks++; if (rdy !== 2'b01) begin errors++; $display("FAIL req0_zero_ready got %b want 01", rdy); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL req0_zero_latency got %0d want %0d", lat, LAT); end
    checks++; if (od !== '0) begin errors++; $display("FAIL req0_zero_data got %h want 0", od); end
    checks++; if (oid != 0) begin errors++; $display("FAIL req0_zero_id got %0d want 0", oid); end
    release_out();
    last_g = 0;
  endtask

  task automatic test_req1_word0();
    logic [N_REQ-1:0] rdy; int lat; logic [SW-1:0] od, exp; int oid; bit to;
    req_data = '0;
    req_data[SW +: 64] = 64'h1;
    exp = '0;
    for (int i = 1; i < 10; i++) exp[i*64 +: 64] = 64'h1;
    txn(2'b10, 1'b0, rdy, lat, od, oid, to);
    checks++; if (to || rdy !== 2'b10) begin errors++; $display("FAIL req1_ready got %b want 10", rdy); end
    checks++; if (od !== exp) begin errors++; $display("FAIL req1_data got %h want %h", od, exp); end
    checks++; if (oid != 1) begin errors++; $display("FAIL req1_id got %0d want 1", oid); end
    release_out();
    last_g = 1;
  endtask

  task automatic test_shift_roundtrip();
    logic [N_REQ-1:0] rdy; int lat; logic [SW-1:0] od, od2, exp, orig; int oid; bit to;
    orig = '0;
    orig[63:0] = 64'h0000_0001_0000_0000;
    exp = '0;
    exp[63:0] = 64'h1;
    for (int i = 1; i < 10; i++) exp[i*64 +: 64] = 64'h0000_0001_0000_0001;
    req_data = '0;
    req_data[SW-1:0] = orig;
    txn(2'b01, 1'b0, rdy, lat, od, oid, to);
    checks++; if (to || od !== exp) begin errors++; $display("FAIL shift_data got %h want %h", od, exp); end
    release_out();
    req_data[SW-1:0] = od;
    txn(2'b01, 1'b0, rdy, lat, od2, oid, to);
    checks++; if (to || od2 !== orig) begin errors++; $display("FAIL roundtrip_data got %h want %h", od2, orig); end
    release_out();
    last_g = 0;
  endtask

  task automatic test_alternate();
    logic [N_REQ-1:0] rdy; int lat; logic [SW-1:0] od; int oid; bit to;
    int exp_ids [4] = '{0, 1, 0, 1};
    do_reset();
    req_data = {rand_state(), rand_state()};
    for (int t = 0; t < 4; t++) begin
      txn(2'b11, 1'b1, rdy, lat, od, oid, to);
      checks++; if (to || oid != exp_ids[t]) begin errors++; $display("FAIL alt_id[%0d] got %0d want %0d", t, oid, exp_ids[t]); end
      if (oid >= 0) begin
        checks++;
        if (od !== ref_premix(req_data[oid*SW +: SW])) begin errors++; $display("FAIL alt_data[%0d] got %h want %h", t, od, ref_premix(req_data[oid*SW +: SW])); end
      end
      release_out();
    end
    req_valid = '0;
    last_g = 1;
  endtask

  task automatic test_hold();
    logic [N_REQ-1:0] rdy; int lat; logic [SW-1:0] od; int oid; bit to;
    req_data = {rand_state(), rand_state()};
    txn(2'b11, 1'b1, rdy, lat, od, oid, to);
    checks++; if (to || oid != rr_pick(last_g, 2'b11)) begin errors++; $display("FAIL hold_id got %0d want %0d", oid, rr_pick(last_g, 2'b11)); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== od || int'(out_id) != oid || req_ready !== 2'b00) begin
        errors++;
        $display("FAIL hold_stable[%0d] got valid=%b id=%0d rdy=%b want valid=1 id=%0d rdy=00", c, out_valid, out_id, req_ready, oid);
      end
    end
    req_valid = '0;
    release_out();
    last_g = rr_pick(last_g, 2'b11);
  endtask

  task automatic test_random();
    logic [N_REQ-1:0] rdy, vm; int lat; logic [SW-1:0] od; int oid, eid; bit to;
    for (int t = 0; t < 20; t++) begin
      vm = N_REQ'($urandom_range(1, 3));
      req_data = {rand_state(), rand_state()};
      eid = rr_pick(last_g, vm);
      txn(vm, 1'b0, rdy, lat, od, oid, to);
      checks++;
      if (to || oid != eid || rdy !== (N_REQ'(1) << eid) || lat != LAT) begin
        errors++;
        $display("FAIL rand_ctl[%0d] got id=%0d rdy=%b lat=%0d want id=%0d lat=%0d", t, oid, rdy, lat, eid, LAT);
      end
      checks++;
      if (od !== ref_premix(req_data[eid*SW +: SW])) begin errors++; $display("FAIL rand_data[%0d] got %h want %h", t, od, ref_premix(req_data[eid*SW +: SW])); end
      if (!to) release_out();
      last_g = eid;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    req_data = {rand_state(), rand_state()};
    req_valid = 2'b01; #1;
    n = 0;
    while (req_ready == '0 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_idle got valid=%b busy=%b want 0 0", out_valid, busy); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL midrst_data got %h want 0", out_data); end
    rst = 1'b0;
    last_g = N_REQ - 1;
    req_valid = 2'b11; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL midrst_first_grant got %b want 01", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 30);
    checks++; if (!out_valid || out_id !== 1'b0) begin errors++; $display("FAIL midrst_result got valid=%b id=%0d want 1 0", out_valid, out_id); end
    release_out();
    last_g = 0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; out_ready = 1'b0; req_data = '0;
    test_reset();
    test_req0_zero();
    test_req1_word0();
    test_shift_roundtrip();
    test_alternate();
    test_hold();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
